// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: scan control handshake and captured-result bus
interface truth_table_scanner_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic [2**N_IN-1:0]   minterms;
    logic [N_IN:0]        count;

    modport master (output start, abort, input busy, done, minterms, count);
    modport slave  (input start, abort, output busy, done, minterms, count);
endinterface

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps all input combinations of a boolean function and captures its minterm mask
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_scanner_if.slave     bus,
    output logic [N_IN-1:0]          dut_in,
    input  logic                     dut_out
);
    localparam int M  = 2**N_IN;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    minterms_q, minterms_d;
    logic [N_IN:0]   count_q, count_d;

    assign bus.busy     = state_q == WAIT;
    assign bus.done     = state_q == DONE;
    assign bus.minterms = minterms_q;
    assign bus.count    = count_q;
    assign dut_in       = state_q == WAIT ? idx_q : '0;

    // next-state: step through combinations, sampling dut_out on the last settle cycle of each
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        minterms_d = minterms_q;
        count_d    = count_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d    = WAIT;
                idx_d      = '0;
                cnt_d      = '0;
                minterms_d = '0;
                count_d    = '0;
            end
            WAIT: if (bus.abort) begin
                state_d = IDLE;
            end else if (cnt_q == CW'(SETTLE - 1)) begin
                minterms_d[idx_q] = dut_out;
                count_d           = count_q + (N_IN+1)'(dut_out);
                cnt_d             = '0;
                if (idx_q == N_IN'(M - 1))
                    state_d = DONE;
                else
                    idx_d = idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            minterms_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            minterms_q <= minterms_d;
            count_q    <= count_d;
        end
    end
endmodule
